// File: rtl/seg7_scan_if.sv
// Bus between the seven-segment pattern source and the scan multiplexer.
// The master side drives the control inputs and the patterns. The slave side
// drives the display pins.
interface seg7_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                           enable;
  logic [3:0]                     bright;
  logic [NUM_DIGITS-1:0][7:0]     seg_in;   // digit k pattern in seg_in[k]
  logic [7:0]                     seg_out;
  logic [NUM_DIGITS-1:0]          dig_sel;
  logic                           frame_tick;

  modport master (
    output enable, bright, seg_in,
    input  seg_out, dig_sel, frame_tick
  );

  modport slave (
    input  enable, bright, seg_in,
    output seg_out, dig_sel, frame_tick
  );
endinterface

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed seven-segment driver.
// Each digit gets a slot of SCAN_DIV cycles. Every digit is dark for the
// first BLANK_CYC cycles of a slot. The rest of the slot is the ON window,
// where a 4-bit PWM gates the selected digit. A digit's pattern is captured
// once at the start of its slot, so changes mid-slot wait for the next visit.
module seg7_scan_mux #(
  parameter int NUM_DIGITS     = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int BLANK_CYC      = 200,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input logic         clk,
  input logic         rst_n,
  seg7_scan_if.slave  bus
);
  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  // Pin polarity masks. The "off" value at the pins is the mask itself.
  localparam logic [7:0]            SEG_XOR = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_XOR = (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}}
                                                                    : {NUM_DIGITS{1'b0}};

  typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

  state_t                 state;
  logic [CNT_W-1:0]       slot_cnt;
  logic [IDX_W-1:0]       dig_idx;
  logic [IDX_W-1:0]       nxt_idx;
  logic [3:0]             pwm_cnt;
  logic [7:0]             snapshot;
  logic [7:0]             seg_q;
  logic [NUM_DIGITS-1:0]  dig_q;
  logic                   tick_q;
  logic                   lit;
  logic [NUM_DIGITS-1:0]  onehot;

  // Next digit in scan order, wrapping at the last digit.
  always_comb begin
    nxt_idx = (dig_idx == IDX_LAST) ? '0 : dig_idx + 1'b1;
  end

  // Decide whether the current digit is lit this cycle. A digit is lit only
  // in the ON window while the PWM count is below the brightness.
  always_comb begin
    lit    = (state == ON) && (pwm_cnt < bus.bright);
    onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << dig_idx;
  end

  // Scan FSM. The pin outputs are registered from the pre-edge state, so
  // they trail the FSM by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      slot_cnt <= '0;
      dig_idx  <= '0;
      pwm_cnt  <= '0;
      snapshot <= '0;
      seg_q    <= SEG_XOR;
      dig_q    <= DIG_XOR;
      tick_q   <= 1'b0;
    end else begin
      // Segments are forced off whenever no digit is selected.
      seg_q  <= (lit ? snapshot : 8'h00) ^ SEG_XOR;
      dig_q  <= (lit ? onehot : '0) ^ DIG_XOR;
      tick_q <= 1'b0;

      if (!bus.enable) begin
        // Dropping enable wins over any slot-end advance.
        state    <= IDLE;
        slot_cnt <= '0;
        dig_idx  <= '0;
        pwm_cnt  <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            state    <= BLANK;
            slot_cnt <= '0;
            dig_idx  <= '0;
            snapshot <= bus.seg_in[0];
            tick_q   <= 1'b1;
          end
          BLANK: begin
            slot_cnt <= slot_cnt + 1'b1;
            if (slot_cnt == BLANK_LAST) begin
              state   <= ON;
              pwm_cnt <= '0;
            end
          end
          ON: begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (slot_cnt == SLOT_LAST) begin
              slot_cnt <= '0;
              state    <= BLANK;
              dig_idx  <= nxt_idx;
              snapshot <= bus.seg_in[nxt_idx];
              tick_q   <= (nxt_idx == '0);
            end else begin
              slot_cnt <= slot_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.dig_sel    = dig_q;
  assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux with 4 digits, 40-cycle slots and an 8-cycle blank.
// The reference tracks the elapsed cycle count since scanning started. From
// that count it derives the slot, the offset in the slot and the PWM phase.
module tb_seg7_scan_mux;
  localparam int ND = 4;
  localparam int SD = 40;
  localparam int BC = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_if #(.NUM_DIGITS(ND)) bus ();

  seg7_scan_mux #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC),
    .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference state: whether scanning is running, and the number of edges
  // since the start edge.
  bit         running = 1'b0;
  int         pos = 0;
  logic [7:0] snap [ND];
  logic [7:0] exp_seg = 8'h00;
  logic [3:0] exp_dig = 4'b1111;
  logic       exp_ft = 1'b0;

  function automatic void model_reset();
    running = 1'b0;
    pos     = 0;
    exp_seg = 8'h00;
    exp_dig = 4'b1111;
    exp_ft  = 1'b0;
  endfunction

  // Advance the reference by one clock edge, using the inputs as sampled.
  function automatic void model_edge();
    int  off, d;
    bit  on;
    off = pos % SD;
    d   = (pos / SD) % ND;
    on  = running && (off >= BC) && (((off - BC) % 16) < int'(bus.bright));
    exp_seg = on ? snap[d] : 8'h00;
    exp_dig = on ? ~(4'b0001 << d) : 4'b1111;
    if (!bus.enable) begin
      running = 1'b0;
      exp_ft  = 1'b0;
    end else if (!running) begin
      running = 1'b1;
      pos     = 0;
      snap[0] = bus.seg_in[0];
      exp_ft  = 1'b1;
    end else begin
      pos++;
      if (pos % SD == 0) snap[(pos / SD) % ND] = bus.seg_in[(pos / SD) % ND];
      exp_ft = (pos % (ND * SD) == 0);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if ({bus.seg_out, bus.dig_sel, bus.frame_tick} !== {8'h00, 4'b1111, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_async: got %h %b %b want 00 1111 0", bus.seg_out, bus.dig_sel, bus.frame_tick);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++;
      if ({bus.seg_out, bus.dig_sel, bus.frame_tick} !== {8'h00, 4'b1111, 1'b0}) begin
        miscompares++;
        $display("FAIL reset_hold: got %h %b %b want 00 1111 0", bus.seg_out, bus.dig_sel, bus.frame_tick);
      end
    end
  endtask

  task automatic test_scan();
    int ticks = 0, d0 = 0, d3 = 0, last = -1;
    int order[$];
    bus.bright = 4'd15;
    bus.seg_in = {8'hF2, 8'hDA, 8'h60, 8'hFC};
    bus.enable = 1'b1;
    for (int i = 0; i < 320; i++) begin
      tick();
      vectors++;
      if ({bus.seg_out, bus.dig_sel, bus.frame_tick} !== {exp_seg, exp_dig, exp_ft}) begin
        miscompares++;
        $display("FAIL scan_cycle%0d: got %h %b %b want %h %b %b", i, bus.seg_out, bus.dig_sel,
                 bus.frame_tick, exp_seg, exp_dig, exp_ft);
      end
      if (bus.frame_tick === 1'b1) ticks++;
      if (i < 160 && bus.dig_sel === 4'b1110 && bus.seg_out === 8'hFC) d0++;
      if (bus.dig_sel === 4'b0111 && bus.seg_out === 8'hF2) d3++;
      for (int k = 0; k < ND; k++)
        if (bus.dig_sel[k] === 1'b0 && k != last) begin
          order.push_back(k);
          last = k;
        end
    end
    vectors++;
    if (ticks != 2) begin
      miscompares++;
      $display("FAIL frame_tick_count: got %0d want 2", ticks);
    end
    vectors++;
    if (d0 != 30) begin
      miscompares++;
      $display("FAIL digit0_on_cycles: got %0d want 30", d0);
    end
    vectors++;
    if (d3 != 60) begin
      miscompares++;
      $display("FAIL digit3_on_cycles: got %0d want 60", d3);
    end
    vectors++;
    if (order.size() != 8) begin
      miscompares++;
      $display("FAIL slot_order_len: got %0d want 8", order.size());
    end else begin
      for (int j = 0; j < 8; j++)
        if (order[j] != j % 4) begin
          miscompares++;
          $display("FAIL slot_order[%0d]: got %0d want %0d", j, order[j], j % 4);
        end
    end
  endtask

  task automatic test_bright();
    int on0 = 0, on8 = 0;
    bus.bright = 4'd0;
    for (int i = 0; i < 160; i++) begin
      tick();
      vectors++;
      if ({bus.seg_out, bus.dig_sel, bus.frame_tick} !== {exp_seg, exp_dig, exp_ft}) begin
        miscompares++;
        $display("FAIL bright0_cycle%0d: got %h %b want %h %b", i, bus.seg_out, bus.dig_sel, exp_seg, exp_dig);
      end
      if (bus.dig_sel !== 4'b1111 || bus.seg_out !== 8'h00) on0++;
    end
    vectors++;
    if (on0 != 0) begin
      miscompares++;
      $display("FAIL bright0_dark: got %0d lit cycles want 0", on0);
    end
    bus.bright = 4'd8;
    for (int i = 0; i < 160; i++) begin
      tick();
      vectors++;
      if ({bus.seg_out, bus.dig_sel, bus.frame_tick} !== {exp_seg, exp_dig, exp_ft}) begin
        miscompares++;
        $display("FAIL bright8_cycle%0d: got %h %b want %h %b", i, bus.seg_out, bus.dig_sel, exp_seg, exp_dig);
      end
      if (bus.dig_sel !== 4'b1111) on8++;
    end
    vectors++;
    if (on8 != 64) begin
      miscompares++;
      $display("FAIL bright8_duty: got %0d lit cycles per frame want 64", on8);
    end
  endtask

  task automatic test_snapshot();
    int guard = 0, stale = 0, bad = 0;
    bit seen = 1'b0;
    bus.bright = 4'd15;
    while (!(running && (pos / SD) % ND == 0 && pos % SD >= 14 && pos % SD <= 20) && guard < 400) begin
      tick();
      guard++;
    end
    vectors++;
    if (guard >= 400) begin
      miscompares++;
      $display("FAIL snap_sync: digit0 slot not reached, got %0d cycles want < 400", guard);
    end
    bus.seg_in[0] = 8'h60;
    for (int i = 0; i < 200; i++) begin
      tick();
      vectors++;
      if ({bus.seg_out, bus.dig_sel, bus.frame_tick} !== {exp_seg, exp_dig, exp_ft}) begin
        miscompares++;
        $display("FAIL snap_cycle%0d: got %h %b want %h %b", i, bus.seg_out, bus.dig_sel, exp_seg, exp_dig);
      end
      if (bus.dig_sel === 4'b1110) begin
        if (!seen && i < 30 && bus.seg_out !== 8'hFC) stale++;
        if (i >= 100 && bus.seg_out !== 8'h60) bad++;
        if (i >= 100) seen = 1'b1;
      end
    end
    vectors++;
    if (stale != 0) begin
      miscompares++;
      $display("FAIL snap_hold: got %0d cycles not FC want 0", stale);
    end
    vectors++;
    if (!seen || bad != 0) begin
      miscompares++;
      $display("FAIL snap_update: got seen=%0d bad=%0d want seen=1 bad=0", seen, bad);
    end
  endtask

  task automatic test_enable_drop();
    int guard = 0, dark = 0;
    while (!(running && pos % SD >= BC + 4 && pos % SD < SD - 4) && guard < 200) begin
      tick();
      guard++;
    end
    bus.enable = 1'b0;
    tick();
    tick();
    vectors++;
    if (bus.dig_sel !== 4'b1111 || bus.seg_out !== 8'h00) begin
      miscompares++;
      $display("FAIL enable_drop: got %h %b want 00 1111", bus.seg_out, bus.dig_sel);
    end
    for (int i = 0; i < 3; i++) tick();
    bus.enable = 1'b1;
    tick();
    vectors++;
    if (bus.frame_tick !== 1'b1) begin
      miscompares++;
      $display("FAIL reenable_tick: got %b want 1", bus.frame_tick);
    end
    while (bus.dig_sel === 4'b1111 && dark < 50) begin
      tick();
      if (bus.dig_sel === 4'b1111) dark++;
    end
    vectors++;
    if (dark != BC || bus.dig_sel !== 4'b1110) begin
      miscompares++;
      $display("FAIL reenable_gap: got %0d dark cycles then %b want %0d then 1110", dark, bus.dig_sel, BC);
    end
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    while (!(running && (pos / SD) % ND == 2 && pos % SD > BC + 2) && guard < 400) begin
      tick();
      guard++;
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    vectors++;
    if ({bus.seg_out, bus.dig_sel, bus.frame_tick} !== {8'h00, 4'b1111, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid: got %h %b %b want 00 1111 0", bus.seg_out, bus.dig_sel, bus.frame_tick);
    end
    #1 rst_n = 1'b1;
    guard = 0;
    do begin
      tick();
      guard++;
      vectors++;
      if ({bus.seg_out, bus.dig_sel, bus.frame_tick} !== {exp_seg, exp_dig, exp_ft}) begin
        miscompares++;
        $display("FAIL reset_restart%0d: got %h %b want %h %b", guard, bus.seg_out, bus.dig_sel, exp_seg, exp_dig);
      end
    end while (bus.dig_sel === 4'b1111 && guard < 60);
    vectors++;
    if (bus.dig_sel !== 4'b1110) begin
      miscompares++;
      $display("FAIL reset_first_digit: got %b want 1110", bus.dig_sel);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 29) == 0) bus.seg_in[$urandom_range(0, ND - 1)] = 8'($urandom);
      if ($urandom_range(0, 99) == 0) bus.bright = 4'($urandom);
      if ($urandom_range(0, 199) == 0) bus.enable = ~bus.enable;
      else if (!bus.enable && $urandom_range(0, 9) == 0) bus.enable = 1'b1;
      tick();
      vectors++;
      if ({bus.seg_out, bus.dig_sel, bus.frame_tick} !== {exp_seg, exp_dig, exp_ft}) begin
        miscompares++;
        $display("FAIL random_cycle%0d: got %h %b %b want %h %b %b", i, bus.seg_out, bus.dig_sel,
                 bus.frame_tick, exp_seg, exp_dig, exp_ft);
      end
    end
  endtask

  initial begin
    bus.enable = 1'b0;
    bus.bright = 4'd0;
    bus.seg_in = '0;
    for (int k = 0; k < ND; k++) snap[k] = 8'h00;
    test_reset();
    test_scan();
    test_bright();
    test_snapshot();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
